// File: rtl/cnn_addrgen_pkg.sv
// Shared types and elaboration helpers for the CNN address generators.
package cnn_addrgen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  // Output map side for a square input map.
  function automatic int calc_out_w(input int w, input int k, input int s, input int p);
    return (w + 2 * p - k) / s + 1;
  endfunction

  // Two taps per beat, so an odd tap count leaves a half-empty final pair.
  function automatic int calc_pairs(input int taps);
    return (taps + 1) / 2;
  endfunction

endpackage

// File: rtl/conv_tap_addr.sv
// Maps one kernel tap of one output pixel to a feature-memory address,
// flagging taps that fall into the zero-padding border.
module conv_tap_addr
  import cnn_addrgen_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int W          = 16,
  parameter int K          = 5,
  parameter int S          = 1,
  parameter int P          = 0,
  parameter int OB         = 4,
  parameter int KB         = 3,
  parameter int GB         = 1
) (
  input  logic [OB-1:0]         i,
  input  logic [OB-1:0]         j,
  input  logic [KB-1:0]         km,
  input  logic [KB-1:0]         kn,
  input  logic [GB-1:0]         g,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  pad
);

  localparam int OUT_W   = calc_out_w(W, K, S, P);
  localparam int CH_SIZE = W * W;
  localparam int CW      = clog2(OUT_W * S + K + W + P + 1) + 1;
  localparam logic signed [CW-1:0] W_S = CW'(W);

  logic signed [CW-1:0] r;
  logic signed [CW-1:0] c;

  // Signed row/column of the tap, then the border test and linear address.
  always_comb begin
    r = CW'(i) * CW'(S) + CW'(km) - CW'(P);
    c = CW'(j) * CW'(S) + CW'(kn) - CW'(P);
    pad = r[CW-1] || (r >= W_S) || c[CW-1] || (c >= W_S);
    addr = '0;
    if (!pad) begin
      addr = ADDR_WIDTH'(g) * ADDR_WIDTH'(CH_SIZE)
           + ADDR_WIDTH'(r) * ADDR_WIDTH'(W)
           + ADDR_WIDTH'(c);
    end
  end

endmodule

// File: rtl/conv_pair_addrgen_param.sv
// Sliding-window read-address generator: two kernel taps per beat for a
// dual-port feature RAM, swept over channel groups, output pixels and passes.
module conv_pair_addrgen_param
  import cnn_addrgen_pkg::*;
#(
  parameter int ADDR_WIDTH       = 12,
  parameter int IN_FEATURE_WIDTH = 16,
  parameter int KERNEL_WIDTH     = 5,
  parameter int STRIDE           = 1,
  parameter int PAD              = 0,
  parameter int NUM_IN_CH        = 4,
  parameter int IFMAP_PAR        = 2,
  parameter int NUM_OUT_PASS     = 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     start,
  input  logic                                     out_ready,
  output logic                                     out_valid,
  output logic [ADDR_WIDTH-1:0]                    addr_a,
  output logic [ADDR_WIDTH-1:0]                    addr_b,
  output logic                                     pad_a,
  output logic                                     pad_b,
  output logic                                     b_en,
  output logic                                     win_last,
  output logic [clog2(NUM_IN_CH/IFMAP_PAR)-1:0]    ch_grp,
  output logic                                     busy,
  output logic                                     done
);

  localparam int G        = NUM_IN_CH / IFMAP_PAR;
  localparam int OUT_W    = calc_out_w(IN_FEATURE_WIDTH, KERNEL_WIDTH, STRIDE, PAD);
  localparam int TAPS     = KERNEL_WIDTH * KERNEL_WIDTH;
  localparam int PAIRS    = calc_pairs(TAPS);
  localparam int CH_SIZE  = IN_FEATURE_WIDTH * IN_FEATURE_WIDTH;
  localparam bit ODD_TAPS = (TAPS % 2) == 1;
  localparam int PB = clog2(PAIRS);
  localparam int GB = clog2(G);
  localparam int OB = clog2(OUT_W);
  localparam int QB = clog2(NUM_OUT_PASS);
  localparam int KB = clog2(KERNEL_WIDTH + 1);
  localparam logic [KB:0] K_EXT = (KB+1)'(KERNEL_WIDTH);
  localparam logic [KB:0] TWO   = (KB+1)'(2);

  if (64'(G) * 64'(CH_SIZE) > (64'd1 << ADDR_WIDTH)) begin : g_addr_space_check
    $error("feature memory does not fit in ADDR_WIDTH bits");
  end

  state_t state, state_next;
  logic [PB-1:0] p;
  logic [GB-1:0] g;
  logic [OB-1:0] j;
  logic [OB-1:0] i;
  logic [QB-1:0] q;
  logic [KB-1:0] km, kn;
  logic [KB-1:0] km_b, kn_b;
  logic [KB:0]   kn_plus2;
  logic last_p, last_g, last_j, last_i, last_q, final_beat, fire, b_exists;
  logic [ADDR_WIDTH-1:0] tap_addr_a, tap_addr_b;
  logic tap_pad_a, tap_pad_b;

  // Loop-end flags, the handshake, and the B tap as the successor of the A tap.
  always_comb begin
    last_p     = p == PB'(PAIRS - 1);
    last_g     = g == GB'(G - 1);
    last_j     = j == OB'(OUT_W - 1);
    last_i     = i == OB'(OUT_W - 1);
    last_q     = q == QB'(NUM_OUT_PASS - 1);
    final_beat = last_p && last_g && last_j && last_i && last_q;
    fire       = (state == RUN) && out_ready;
    b_exists   = !(ODD_TAPS && last_p);
    kn_plus2   = {1'b0, kn} + TWO;
    if (kn == KB'(KERNEL_WIDTH - 1)) begin
      kn_b = '0;
      km_b = km + KB'(1);
    end else begin
      kn_b = kn + KB'(1);
      km_b = km;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: start is only honoured from IDLE, DONE is a single cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (fire && final_beat) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Nested loop counters; the A tap row/column steps by two taps without a divider.
  always_ff @(posedge clk) begin
    if (!reset || state != RUN) begin
      p  <= '0;
      g  <= '0;
      j  <= '0;
      i  <= '0;
      q  <= '0;
      km <= '0;
      kn <= '0;
    end else if (fire) begin
      if (last_p) begin
        p  <= '0;
        km <= '0;
        kn <= '0;
        if (last_g) begin
          g <= '0;
          if (last_j) begin
            j <= '0;
            if (last_i) begin
              i <= '0;
              q <= last_q ? '0 : q + QB'(1);
            end else begin
              i <= i + OB'(1);
            end
          end else begin
            j <= j + OB'(1);
          end
        end else begin
          g <= g + GB'(1);
        end
      end else begin
        p <= p + PB'(1);
        if (kn_plus2 >= K_EXT) begin
          kn <= KB'(kn_plus2 - K_EXT);
          km <= km + KB'(1);
        end else begin
          kn <= KB'(kn_plus2);
        end
      end
    end
  end

  conv_tap_addr #(
    .ADDR_WIDTH(ADDR_WIDTH), .W(IN_FEATURE_WIDTH), .K(KERNEL_WIDTH),
    .S(STRIDE), .P(PAD), .OB(OB), .KB(KB), .GB(GB)
  ) u_tap_a (
    .i(i), .j(j), .km(km), .kn(kn), .g(g), .addr(tap_addr_a), .pad(tap_pad_a)
  );

  conv_tap_addr #(
    .ADDR_WIDTH(ADDR_WIDTH), .W(IN_FEATURE_WIDTH), .K(KERNEL_WIDTH),
    .S(STRIDE), .P(PAD), .OB(OB), .KB(KB), .GB(GB)
  ) u_tap_b (
    .i(i), .j(j), .km(km_b), .kn(kn_b), .g(g), .addr(tap_addr_b), .pad(tap_pad_b)
  );

  // Beat outputs are only non-zero while running; the missing B tap reads as zero.
  always_comb begin
    out_valid = 1'b0;
    addr_a    = '0;
    addr_b    = '0;
    pad_a     = 1'b0;
    pad_b     = 1'b0;
    b_en      = 1'b0;
    win_last  = 1'b0;
    ch_grp    = '0;
    busy      = state != IDLE;
    done      = state == DONE;
    if (state == RUN) begin
      out_valid = 1'b1;
      addr_a    = tap_addr_a;
      pad_a     = tap_pad_a;
      b_en      = b_exists;
      addr_b    = b_exists ? tap_addr_b : '0;
      pad_b     = b_exists && tap_pad_b;
      win_last  = last_p && last_g;
      ch_grp    = g;
    end
  end

endmodule

// File: tb/tb_conv_pair_addrgen_param.sv
// Directed bench for conv_pair_addrgen_param across four parameter sets.
module tb_conv_pair_addrgen_param;

  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic        pa;
    logic        pb;
    logic        ben;
    logic        wl;
    logic        g;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  logic out_ready;
  logic [3:0] start;
  logic [3:0] valid, pad_a, pad_b, b_en, win_last, busy, done, grp;
  logic [3:0][11:0] addr_a, addr_b;

  beat_t beats[$];
  int sel = 0;
  int done_cnt [4] = '{default: 0};
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  conv_pair_addrgen_param d0 (
    .clk(clk), .reset(reset), .start(start[0]), .out_ready(out_ready),
    .out_valid(valid[0]), .addr_a(addr_a[0]), .addr_b(addr_b[0]), .pad_a(pad_a[0]),
    .pad_b(pad_b[0]), .b_en(b_en[0]), .win_last(win_last[0]), .ch_grp(grp[0:0]),
    .busy(busy[0]), .done(done[0])
  );

  conv_pair_addrgen_param #(.IN_FEATURE_WIDTH(4), .KERNEL_WIDTH(3), .PAD(1)) d1 (
    .clk(clk), .reset(reset), .start(start[1]), .out_ready(out_ready),
    .out_valid(valid[1]), .addr_a(addr_a[1]), .addr_b(addr_b[1]), .pad_a(pad_a[1]),
    .pad_b(pad_b[1]), .b_en(b_en[1]), .win_last(win_last[1]), .ch_grp(grp[1:1]),
    .busy(busy[1]), .done(done[1])
  );

  conv_pair_addrgen_param #(.IN_FEATURE_WIDTH(8), .KERNEL_WIDTH(3), .STRIDE(2)) d2 (
    .clk(clk), .reset(reset), .start(start[2]), .out_ready(out_ready),
    .out_valid(valid[2]), .addr_a(addr_a[2]), .addr_b(addr_b[2]), .pad_a(pad_a[2]),
    .pad_b(pad_b[2]), .b_en(b_en[2]), .win_last(win_last[2]), .ch_grp(grp[2:2]),
    .busy(busy[2]), .done(done[2])
  );

  conv_pair_addrgen_param #(.IN_FEATURE_WIDTH(4), .KERNEL_WIDTH(3), .NUM_IN_CH(2),
                            .IFMAP_PAR(2), .NUM_OUT_PASS(2)) d3 (
    .clk(clk), .reset(reset), .start(start[3]), .out_ready(out_ready),
    .out_valid(valid[3]), .addr_a(addr_a[3]), .addr_b(addr_b[3]), .pad_a(pad_a[3]),
    .pad_b(pad_b[3]), .b_en(b_en[3]), .win_last(win_last[3]), .ch_grp(grp[3:3]),
    .busy(busy[3]), .done(done[3])
  );

  // Record every accepted beat of the instance under test, and count done pulses.
  always @(posedge clk) begin
    if (valid[sel] && out_ready)
      beats.push_back({addr_a[sel], addr_b[sel], pad_a[sel], pad_b[sel],
                       b_en[sel], win_last[sel], grp[sel]});
    for (int k = 0; k < 4; k++)
      if (done[k]) done_cnt[k] = done_cnt[k] + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic [11:0] a,
                           input logic [11:0] b, input logic pa, input logic pb,
                           input logic ben, input logic wl, input logic g);
    beat_t got;
    got = beats[idx];
    checkOutput(tag, {3'b0, got}, {3'b0, a, b, pa, pb, ben, wl, g});
  endtask

  // One-cycle start pulse; returns on the negedge where the first beat is shown.
  task automatic applyStimulus(input int inst);
    @(negedge clk);
    start[inst] = 1'b1;
    @(negedge clk);
    start[inst] = 1'b0;
  endtask

  // Waits for the done pulse of one instance within a cycle budget.
  task automatic waitDone(input int inst, input int budget, input string tag);
    int n;
    n = 0;
    while (!done[inst] && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, {31'b0, done[inst]}, 32'd1);
  endtask

  initial begin
    reset     = 1'b0;
    out_ready = 1'b1;
    start     = '0;
    repeat (3) @(negedge clk);
    checkOutput("d0_reset_state", {valid[0], addr_a[0], addr_b[0], pad_a[0], pad_b[0],
                b_en[0], win_last[0], grp[0], busy[0], done[0]}, 32'd0);
    checkOutput("d1_reset_state", {valid[1], addr_a[1], addr_b[1], pad_a[1], pad_b[1],
                b_en[1], win_last[1], grp[1], busy[1], done[1]}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] default sweep with backpressure and ignored start");
    sel = 0;
    beats.delete();
    applyStimulus(0);
    checkOutput("d0_first_beat", {6'b0, valid[0], busy[0], addr_a[0], addr_b[0]},
                {6'b0, 1'b1, 1'b1, 12'd0, 12'd1});
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    start[0]  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      start[0] = 1'b0;
      checkOutput("d0_stall_hold", {7'b0, valid[0], addr_a[0], addr_b[0]},
                  {7'b0, 1'b1, 12'd4, 12'd16});
    end
    out_ready = 1'b1;
    waitDone(0, 5000, "d0_done_timeout");
    checkOutput("d0_done_cycle", {29'b0, valid[0], busy[0], done[0]}, {29'b0, 3'b011});
    @(negedge clk);
    checkOutput("d0_after_done", {30'b0, busy[0], done[0]}, 32'd0);
    checkOutput("d0_beat_count", beats.size(), 32'd3744);
    checkOutput("d0_done_pulses", done_cnt[0], 32'd1);
    checkBeat("d0_beat0",    0,  12'd0,   12'd1,   0, 0, 1, 0, 0);
    checkBeat("d0_beat1",    1,  12'd2,   12'd3,   0, 0, 1, 0, 0);
    checkBeat("d0_beat2",    2,  12'd4,   12'd16,  0, 0, 1, 0, 0);
    checkBeat("d0_beat3",    3,  12'd17,  12'd18,  0, 0, 1, 0, 0);
    checkBeat("d0_p12_g0",   12, 12'd68,  12'd0,   0, 0, 0, 0, 0);
    checkBeat("d0_p0_g1",    13, 12'd256, 12'd257, 0, 0, 1, 0, 1);
    checkBeat("d0_p12_g1",   25, 12'd324, 12'd0,   0, 0, 0, 1, 1);
    checkBeat("d0_win01",    26, 12'd1,   12'd2,   0, 0, 1, 0, 0);
    checkBeat("d0_last",   3743, 12'd511, 12'd0,   0, 0, 0, 1, 1);

    $display("[TB] reset asserted mid-sweep");
    beats.delete();
    applyStimulus(0);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("d0_mid_reset", {valid[0], addr_a[0], addr_b[0], pad_a[0], pad_b[0],
                b_en[0], win_last[0], grp[0], busy[0], done[0]}, 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("d0_no_done_after_abort", {busy[0], 31'b0} | done_cnt[0], 32'd1);
    applyStimulus(0);
    checkOutput("d0_restart", {7'b0, valid[0], addr_a[0], addr_b[0]},
                {7'b0, 1'b1, 12'd0, 12'd1});
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    $display("[TB] padded 4x4 map, 3x3 kernel");
    sel = 1;
    beats.delete();
    applyStimulus(1);
    waitDone(1, 1000, "d1_done_timeout");
    checkOutput("d1_beat_count", beats.size(), 32'd160);
    checkBeat("d1_beat0",  0,  12'd0,  12'd0, 1, 1, 1, 0, 0);
    checkBeat("d1_beat1",  1,  12'd0,  12'd0, 1, 1, 1, 0, 0);
    checkBeat("d1_beat2",  2,  12'd0,  12'd1, 0, 0, 1, 0, 0);
    checkBeat("d1_beat3",  3,  12'd0,  12'd4, 1, 0, 1, 0, 0);
    checkBeat("d1_beat4",  4,  12'd5,  12'd0, 0, 0, 0, 0, 0);
    checkBeat("d1_g1_end", 9,  12'd21, 12'd0, 0, 0, 0, 1, 1);
    checkBeat("d1_last", 159,  12'd0,  12'd0, 1, 0, 0, 1, 1);

    $display("[TB] stride 2 on 8x8 map");
    sel = 2;
    beats.delete();
    applyStimulus(2);
    waitDone(2, 1000, "d2_done_timeout");
    checkOutput("d2_beat_count", beats.size(), 32'd90);
    checkBeat("d2_beat0",  0, 12'd0,   12'd1,  0, 0, 1, 0, 0);
    checkBeat("d2_win01", 10, 12'd2,   12'd3,  0, 0, 1, 0, 0);
    checkBeat("d2_win10", 30, 12'd16,  12'd17, 0, 0, 1, 0, 0);
    checkBeat("d2_last",  89, 12'd118, 12'd0,  0, 0, 0, 1, 1);

    $display("[TB] two output passes with start re-pulsed while busy");
    sel = 3;
    beats.delete();
    applyStimulus(3);
    @(negedge clk);
    start[3] = 1'b1;
    @(negedge clk);
    start[3] = 1'b0;
    waitDone(3, 1000, "d3_done_timeout");
    @(negedge clk);
    checkOutput("d3_beat_count", beats.size(), 32'd40);
    checkOutput("d3_done_pulses", done_cnt[3], 32'd1);
    checkBeat("d3_beat0",  0, 12'd0,  12'd1, 0, 0, 1, 0, 0);
    checkBeat("d3_beat4",  4, 12'd10, 12'd0, 0, 0, 0, 1, 0);
    checkBeat("d3_beat5",  5, 12'd1,  12'd2, 0, 0, 1, 0, 0);
    checkBeat("d3_end_q0", 19, 12'd15, 12'd0, 0, 0, 0, 1, 0);
    checkBeat("d3_start_q1", 20, 12'd0, 12'd1, 0, 0, 1, 0, 0);
    checkBeat("d3_end_q1", 39, 12'd15, 12'd0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 20; k++)
      checkOutput($sformatf("d3_repeat_%0d", k), {3'b0, beats[k + 20]}, {3'b0, beats[k]});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_pair_addrgen_param.md
Name: conv_pair_addrgen_param

Overview:
- Parametrised convolution read-address generator for the CNN feature-map buffers.
- Emits two tap addresses per beat (port A and port B of a true-dual-port feature RAM) over each sliding window.
- Adds stride, zero-padding, channel-group and output-pass loops, plus a start/done and valid/ready handshake.
- Sits between the layer controller and the input feature memories; its outputs drive the MAC array operand fetch.

Parameters:
- ADDR_WIDTH, 12, feature-memory address width.
- IN_FEATURE_WIDTH, 16, input map side W (square maps).
- KERNEL_WIDTH, 5, kernel side K.
- STRIDE, 1, convolution stride S (≥1).
- PAD, 0, zero-padding P on each edge.
- NUM_IN_CH, 4, input channels held in one memory.
- IFMAP_PAR, 2, channels read in parallel; channel groups G = NUM_IN_CH/IFMAP_PAR.
- NUM_OUT_PASS, 1, repeats of the full sweep (one per output-map batch).
- Derived localparams: OUT_W=(W+2P-K)/S+1; TAPS=K*K; PAIRS=ceil(TAPS/2); CH_SIZE=W*W.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; starts a sweep when idle.
- out_ready  in  1  consumer accepts the current beat.
- out_valid  out  1  beat valid.
- addr_a  out  ADDR_WIDTH  port A address.
- addr_b  out  ADDR_WIDTH  port B address.
- pad_a  out  1  A tap lies in padding; consumer substitutes 0.
- pad_b  out  1  B tap lies in padding.
- b_en  out  1  B tap exists (0 on odd-TAPS final pair).
- win_last  out  1  last pair of the last channel group of a window (accumulator flush).
- ch_grp  out  clog2(G)  current channel group.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset is synchronous and active-low: while reset is low at a clk edge, the block goes to IDLE and all counters clear. Outputs out_valid, addr_a, addr_b, pad_a, pad_b, b_en, win_last, ch_grp, busy and done are all 0.
- FSM states are IDLE, RUN and DONE.
  - IDLE to RUN on start. The first beat is valid on the cycle after start is sampled (1-cycle latency).
  - RUN to DONE when the final beat is accepted.
  - DONE lasts exactly one cycle (done=1, out_valid=0), then returns to IDLE.
- start is ignored while busy (RUN or DONE). busy is 1 in RUN and DONE.
- Loop order, innermost first:
  - tap-pair index p, 0..PAIRS-1;
  - channel group g, 0..G-1;
  - output column j, 0..OUT_W-1;
  - output row i, 0..OUT_W-1;
  - pass q, 0..NUM_OUT_PASS-1.
- Beats advance only on out_valid&&out_ready. While out_ready=0, every output holds stable.
- Tap mapping:
  - A uses tap tA=2p; B uses tap tB=2p+1.
  - For a tap t: km=t/K, kn=t%K. Track km/kn incrementally, without a divider; kn wraps at K and increments km.
- Coordinates are signed, one bit wider than needed: r=i*S+km-P, c=j*S+kn-P.
- Padding rule:
  - pad=1 iff r<0, r≥W, c<0 or c≥W.
  - When pad=1 the address is forced to 0.
  - Otherwise addr = g*CH_SIZE + r*W + c, truncated to ADDR_WIDTH. Elaboration check: G*CH_SIZE ≤ 2^ADDR_WIDTH.
- B tap edge case: when TAPS is odd and p=PAIRS-1, then b_en=0, addr_b=0 and pad_b=0.
- win_last=1 iff p=PAIRS-1 and g=G-1.
- Final beat: p, g, j, i and q are all at their maxima.
- Wrap rules:
  - the j wrap clears j and increments i;
  - the i wrap clears i and increments q;
  - counters never exceed their bounds.
- Reset asserted mid-RUN aborts the sweep the same cycle; no done pulse is produced.

Decomposition:
- Shared package `cnn_addrgen_pkg`:
  - clog2 function;
  - OUT_W/PAIRS derivation functions;
  - FSM state typedef (IDLE/RUN/DONE).
- One sub-module `conv_tap_addr`: combinational. Inputs are i, j, km, kn and g. Outputs are the address and the pad flag. It is instantiated twice, once for A and once for B.
- Counters, FSM and output registers live in the top module.

Test Plan:
- Defaults (W=16, K=5, S=1, P=0, G=2), out_ready=1, start pulse:
  - first beats are (A,B) = (0,1), (2,3), (4,16);
  - pair p=12 gives addr_a=68, b_en=0, win_last=0 (g=0);
  - p=0 at g=1 gives addr_a=256;
  - 3744 beats in total, then done=1 for one cycle.
- W=4, K=3, P=1, S=1:
  - OUT_W=4;
  - beat 0 has pad_a=1, pad_b=1, both addresses 0;
  - beat 2 (taps 4,5) has addr_a=0 and addr_b=1 with no pad;
  - window i=3, j=3 ends with its last A tap padded.
- W=8, K=3, S=2:
  - OUT_W=3;
  - first beat of window (i=0, j=1) has addr_a=2;
  - first beat of window (i=1, j=0) has addr_a=16.
- Backpressure: drop out_ready for 3 cycles mid-window. Outputs stay constant and no beat is skipped or duplicated; the beat count is unchanged.
- Drive reset low mid-RUN for 1 cycle: all outputs go to 0, there is no done pulse, and a new start restarts from addr_a=0.
- start re-pulsed while busy: ignored. With NUM_OUT_PASS=2 the beat sequence repeats exactly twice before done.
